// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed little-endian byte program into instruction memory, then releases the core from reset.
// Optional checksum byte after the data is enabled with `define LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int Data_Width = 32,
    parameter int Depth      = 100,
    parameter int Len_Width  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  IMem_WE,
    output logic [Data_Width-1:0] IMem_Addr,
    output logic [Data_Width-1:0] IMem_WD,
    output logic                  Core_RST,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t                state_q;
    logic                  ready_q, we_q, core_q, busy_q, done_q, err_q;
    logic [Data_Width-1:0] addr_q, wd_q;
    logic [Len_Width-1:0]  n_q, idx_q;
    logic [1:0]            bidx_q;
    logic [23:0]           buf_q;
    logic [7:0]            csum_q;
    logic                  fire;
    logic [Len_Width-1:0]  len;

    assign fire       = Byte_Valid & ready_q;
    assign len        = Len_Width'({Byte_Data, n_q[7:0]});
    assign Byte_Ready = ready_q;
    assign IMem_WE    = we_q;
    assign IMem_Addr  = addr_q;
    assign IMem_WD    = wd_q;
    assign Core_RST   = core_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Error      = err_q;

    // Load sequencer: header, byte packing, memory writes and core reset release
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            bidx_q  <= '0;
            buf_q   <= '0;
            csum_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    // DONE is entered on the last-byte edge; the write pulse follows, so release one edge later
                    if (state_q == DONE) core_q <= 1'b1;
                    if (Start) begin
                        state_q <= LEN_LO;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        core_q  <= 1'b0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        csum_q  <= '0;
                    end
                end
                LEN_LO: if (fire) begin
                    n_q[7:0] <= Byte_Data;
                    state_q  <= LEN_HI;
                end
                LEN_HI: if (fire) begin
                    n_q    <= len;
                    idx_q  <= '0;
                    bidx_q <= '0;
                    if (len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= CHK;
`else
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else if (len > Len_Width'(Depth)) begin
                        state_q <= ERROR;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (fire) begin
                    bidx_q <= bidx_q + 2'd1;
                    buf_q  <= {Byte_Data, buf_q[23:8]};
                    csum_q <= csum_q ^ Byte_Data;
                    if (bidx_q == 2'd3) begin
                        we_q   <= 1'b1;
                        wd_q   <= Data_Width'({Byte_Data, buf_q});
                        addr_q <= Data_Width'(idx_q) << 2;
                        idx_q  <= idx_q + Len_Width'(1);
                        if (idx_q == n_q - Len_Width'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CHK;
`else
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (fire) begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (Byte_Data == csum_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
